// File: rtl/tt7_sweep_capture_if.sv
// Result channel of tt7_sweep_capture: captured truth table, popcount and compare flag.
// Handshake: master raises result_valid with tt/ones/match stable and holds them until
// a rising edge where result_ready is also high; only that edge transfers the result.
interface tt7_sweep_capture_if;
  logic         result_valid;
  logic         result_ready;
  logic [127:0] tt;
  logic [7:0]   ones;
  logic         match;

  modport master (output result_valid, tt, ones, match, input result_ready);
  modport slave  (input result_valid, tt, ones, match, output result_ready);
endinterface

// File: rtl/tt7_sweep_capture.sv
// Sweeps all 128 minterms of a 7-input function on x, captures f_in into a truth table,
// counts its ones and compares it with a reference table latched at start.
module tt7_sweep_capture #(
  parameter int SAMPLE_DLY = 1,
  parameter int CNT_W      = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [127:0]         expected_tt,
  output logic [CNT_W-1:0]     x,
  input  logic                 f_in,
  output logic                 busy,
  output logic [1:0]           state_dbg,
  tt7_sweep_capture_if.master  res
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state;
  logic         valid_q;
  logic [127:0] tt_q;
  logic [7:0]   ones_q;
  logic         match_q;
  logic [127:0] exp_q;

  // Minterm index whose f_in is due at the coming edge.
  logic             tap_live;
  logic [CNT_W-1:0] tap_idx;

  if (SAMPLE_DLY == 1) begin : g_direct
    assign tap_live = (state == SWEEP);
    assign tap_idx  = x;
  end else begin : g_pipe
    logic [SAMPLE_DLY-2:0] live_q;
    logic [CNT_W-1:0]      idx_q [SAMPLE_DLY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        live_q <= '0;
        for (int j = 0; j < SAMPLE_DLY - 1; j++) idx_q[j] <= '0;
      end else begin
        for (int j = SAMPLE_DLY - 2; j > 0; j--) begin
          live_q[j] <= live_q[j-1];
          idx_q[j]  <= idx_q[j-1];
        end
        live_q[0] <= (state == SWEEP);
        idx_q[0]  <= x;
        // An aborted sweep must not leave captures in flight.
        if (abort) live_q <= '0;
      end
    end

    assign tap_live = live_q[SAMPLE_DLY-2];
    assign tap_idx  = idx_q[SAMPLE_DLY-2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x       <= '0;
      busy    <= 1'b0;
      valid_q <= 1'b0;
      tt_q    <= '0;
      ones_q  <= '0;
      match_q <= 1'b0;
      exp_q   <= '0;
    end else if (abort) begin
      state   <= IDLE;
      x       <= '0;
      busy    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (tap_live) begin
        tt_q[tap_idx] <= f_in;
        ones_q        <= ones_q + 8'(f_in);
      end
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= SWEEP;
            x       <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
            match_q <= 1'b0;
            exp_q   <= expected_tt;
            busy    <= 1'b1;
            valid_q <= 1'b0;
          end else if (state == DONE && res.result_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        SWEEP: begin
          if (x == '1) state <= DRAIN;
          else         x     <= x + 1'b1;
        end
        DRAIN: ;
        default: state <= IDLE;
      endcase
      // Last capture closes the sweep; with SAMPLE_DLY=1 this lands while still in SWEEP.
      if ((state == SWEEP || state == DRAIN) && tap_live && tap_idx == '1) begin
        state   <= DONE;
        busy    <= 1'b0;
        valid_q <= 1'b1;
        match_q <= ({f_in, tt_q[126:0]} == exp_q);
      end
    end
  end

  assign state_dbg        = state;
  assign res.result_valid = valid_q;
  assign res.tt           = tt_q;
  assign res.ones         = ones_q;
  assign res.match        = match_q;

endmodule

// File: doc/tt7_sweep_capture.md
Name: tt7_sweep_capture

Overview:
Exhaustive stimulus-and-capture stage for 7-input Boolean function blocks in the classification flow. On start it drives all 128 input minterms onto x[6:0] in order and samples the combinational function output f_in. It assembles the 128-bit truth table, counts its ones, and compares it against an expected table. The result is handed downstream on a valid/ready handshake. It sits upstream of the function-under-test, driving its x0..x6, and downstream of it, consuming its out.

Parameters:
SAMPLE_DLY, 1, cycles between x update and f_in capture (legal 1..4); covers registered or pipelined function blocks.
CNT_W, 7, minterm counter width; fixed at 7, not to be overridden.

Ports:
clk  in  1  clock, all flops rising-edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin sweep; honoured only in IDLE or DONE.
abort  in  1  cancel sweep; return to IDLE, no result.
expected_tt  in  128  reference truth table; sampled at accepted start.
x  out  7  stimulus; x[0] drives x0 … x[6] drives x6; registered.
f_in  in  1  function output under test.
busy  out  1  high in SWEEP and DRAIN.
result_valid  out  1  result available; held until accepted.
result_ready  in  1  downstream accepts result.
tt  out  128  captured truth table; bit m = f(minterm m), hex MSB-first.
ones  out  8  popcount of tt, 0..128.
match  out  1  tt == latched expected_tt; valid with result_valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; x=0, busy=0, result_valid=0, tt=0, ones=0, match=0, internal counters=0.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE: start=1 at edge E0 -> SWEEP. Same edge: x<=0, tt<=0, ones<=0, expected_tt latched.
- SWEEP: x increments by 1 every edge. Minterm m is on x during the cycle after edge E0+m. After x=127, x holds 127 and state -> DRAIN.
- Capture: f_in is sampled at edge E0+m+SAMPLE_DLY into tt[m]; ones increments when the sampled bit is 1. A capture-index pipeline of depth SAMPLE_DLY tracks m; it must not be recomputed from x.
- DRAIN: waits until capture of m=127 at edge E0+127+SAMPLE_DLY. That same edge sets result_valid=1, computes match, and moves to DONE. For SAMPLE_DLY=1, result_valid is first visible 128 cycles after E0.
- busy=1 exactly in SWEEP and DRAIN.
- DONE: tt, ones and match are held stable while result_valid=1.
  - result_valid && result_ready at an edge: result_valid<=0, state -> IDLE. tt and ones retain their values until the next start.
  - start=1 in DONE without ready: the old result is dropped, result_valid<=0, and a new sweep begins per the IDLE rule.
  - start=1 and result_ready=1 in the same cycle: the handshake completes and the new sweep starts.
- start while busy: ignored.
- abort (any state, synchronous): -> IDLE, busy=0, result_valid=0, x=0. tt and ones are frozen at their partial values. abort takes priority over start and result_ready in the same cycle.
- Async reset mid-sweep: immediate return to the reset values; no result is produced.
- ones width: 8 bits. 128 is reachable (all-ones function) and must not wrap.
- match compares all 128 bits exactly; no masking.
- No other outputs toggle in IDLE.

Test Plan:
- f_in tied 0, SAMPLE_DLY=1, start pulse -> result_valid first high 128 cycles after start edge; tt=0, ones=0; match=1 with expected_tt=0.
- f_in tied 1 -> tt=all F (32 hex digits), ones=128 (0x80, no wrap); match=0 with expected_tt=0.
- f_in=x[0] through a 1-flop register, SAMPLE_DLY=2 -> tt=0xAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA, ones=64.
- f_in=x[6], SAMPLE_DLY=1, expected_tt=0xFFFFFFFF_FFFFFFFF_00000000_00000000 -> identical tt, ones=64, match=1.
- Hold result_ready=0 for 10 cycles after result_valid -> outputs stable; ready=1 for one cycle -> result_valid drops the next edge. Start during busy at cycle 50 -> ignored, result unchanged.
- abort asserted at cycle 60 of a sweep -> busy=0 next edge, x=0, no result_valid. Separately, rst_n pulsed low mid-sweep -> all outputs immediately at reset values. A fresh start afterwards completes normally.
